// File: rtl/alu_cmd_sequencer.sv
// Command/response sequencer in front of a 4-bit combinational ALU.
// MUL is built from four shift-add iterations through the ALU's ADD operation.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// EXEC   | single ALU operation driven from the operand registers
// MUL    | shift-add multiply, four iterations
// RESP   | response held until rsp_ready
module alu_cmd_sequencer #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_signal,
  input  logic [3:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] mq_q, mq_d;
  logic [3:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  logic       cmd_is_mul;
  logic       cmd_is_rsvd;
  logic       carry;
  logic [3:0] mul_hi;
  logic [3:0] mul_lo;

  assign cmd_is_mul  = MUL_EN && (cmd_op == 3'b011);
  assign cmd_is_rsvd = (cmd_op == 3'b100) || (cmd_op == 3'b101) ||
                       ((cmd_op == 3'b011) && !MUL_EN);

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    mq_d       = mq_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    alu_signal = 3'b000;
    carry      = 1'b0;
    mul_hi     = 4'd0;
    mul_lo     = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          a_d   = cmd_a;
          mq_d  = cmd_b;
          acc_d = 4'd0;
          cnt_d = 2'd0;
          if (cmd_is_rsvd) begin
            rsp_data_d = 8'd0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else if (cmd_is_mul) begin
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_a      = a_q;
        alu_b      = mq_q;
        alu_signal = op_q;
        rsp_data_d = {4'd0, alu_out};
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_MUL: begin
        alu_signal = 3'b010;
        alu_a      = acc_q;
        alu_b      = mq_q[0] ? a_q : 4'd0;
        // The ALU has no carry output; a wrapped sum is smaller than its addend.
        carry      = (alu_out < acc_q);
        mul_hi     = {carry, alu_out[3:1]};
        mul_lo     = {alu_out[0], mq_q[3:1]};
        acc_d      = mul_hi;
        mq_d       = mul_lo;
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          rsp_data_d = {mul_hi, mul_lo};
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      a_q        <= 4'd0;
      mq_q       <= 4'd0;
      acc_q      <= 4'd0;
      cnt_q      <= 2'd0;
      rsp_data_q <= 8'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      mq_q       <= mq_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
